stoch_fsm_act: RTL and testbench

Multi-channel, parametrised stochastic FSM activation unit, the successor to the single-channel fixed-depth `stanh`. Each channel is an independent saturating up/down state machine driven by a bipolar stochastic bitstream, which normally comes from `sng`. Each channel emits a transformed bitstream approximating tanh((N_STATES/2)·x) or, in exp mode, exp(−2·G·x). Outputs feed `dru` decoders or downstream stochastic logic, and a valid qualifier lets upstream stall the stream.

---
 rtl/stoch_fsm_act_if.sv | 37 +++
 rtl/stoch_fsm_act.sv | 119 +++++++++++
 tb/tb_stoch_fsm_act.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/stoch_fsm_act_if.sv
// ----------------------------------------------------------------------------
// stoch_fsm_act_if
//   Stream bundle between a stochastic bitstream source, the stoch_fsm_act
//   activation unit and the bitstream consumer.
//
//   Signals:
//     in_valid  - X bits are valid this cycle (driven by upstream)
//     X[CH]     - input bitstream bits, one per channel (driven by upstream)
//     Y[CH]     - output bitstream bits, one per channel (driven by the unit)
//     out_valid - Y is valid this cycle (driven by the unit)
//
//   Modports:
//     master - upstream/consumer side: drives in_valid and X, observes Y and out_valid
//     slave  - activation unit side: observes in_valid and X, drives Y and out_valid
// ----------------------------------------------------------------------------
interface stoch_fsm_act_if #(
  parameter int CH = 4
);
  logic          in_valid;
  logic [CH-1:0] X;
  logic [CH-1:0] Y;
  logic          out_valid;

  modport master (
    output in_valid,
    output X,
    input  Y,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  X,
    output Y,
    output out_valid
  );
endinterface

// File: rtl/stoch_fsm_act.sv
// ----------------------------------------------------------------------------
// stoch_fsm_act
//   Multi-channel stochastic FSM activation unit. Each channel is an
//   independent saturating up/down counter over 0..N_STATES-1 stepped by a
//   bipolar stochastic bitstream. The output bit is a function of the next
//   state:
//     tanh mode : Y = 1 when state >= N_STATES/2   (~ tanh((N_STATES/2)*x))
//     exp  mode : Y = 1 when state <  N_STATES-G   (~ exp(-2*G*x))
//
//   Build option:
//     STOCH_ACT_EXP_EN - when defined, exp mode is compiled in and `mode`
//                        selects the output function. When undefined, `mode`
//                        is ignored and the output is always tanh.
//
//   Parameters:
//     CH       - number of independent channels
//     N_STATES - states per channel (power of two, 4..256)
//     G        - exp-mode threshold offset (1 <= G < N_STATES/2)
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous reset, active-low
//     clr  - synchronous reload of every channel state to N_STATES/2;
//            has priority over in_valid and discards X that cycle
//     mode - 0 = tanh, 1 = exp (only with STOCH_ACT_EXP_EN)
//     bus  - slave side of the stream bundle (in_valid, X in; Y, out_valid out)
//
//   Latency is one cycle: X sampled at an edge shows up on Y after that edge,
//   qualified by out_valid.
// ----------------------------------------------------------------------------
module stoch_fsm_act #(
  parameter int CH       = 4,
  parameter int N_STATES = 8,
  parameter int G        = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                mode,
  stoch_fsm_act_if.slave      bus
);

  // State width follows from the state count; not meant to be overridden.
  localparam int SW = $clog2(N_STATES);

  localparam logic [SW-1:0] MID_STATE = SW'(N_STATES / 2);
  localparam logic [SW-1:0] MAX_STATE = SW'(N_STATES - 1);
  localparam logic [SW-1:0] EXP_TH    = SW'(N_STATES - G);

  logic out_valid_reg;

`ifndef STOCH_ACT_EXP_EN
  // Without exp support the mode input and exp threshold have no load.
  logic unused_exp_cfg;
  assign unused_exp_cfg = mode ^ (^EXP_TH);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [SW-1:0] state_reg;
      logic [SW-1:0] state_next;
      logic          y_reg;
      logic          y_next;

      // Saturating step: never wraps past either end of the range.
      always_comb begin
        state_next = state_reg;
        if (bus.X[gi]) begin
          if (state_reg != MAX_STATE) state_next = state_reg + 1'b1;
        end else begin
          if (state_reg != '0) state_next = state_reg - 1'b1;
        end
      end

      // Output function is evaluated on the state being loaded, so Y
      // reflects this cycle's input bit with a single register of latency.
`ifdef STOCH_ACT_EXP_EN
      always_comb begin
        y_next = (state_next >= MID_STATE);
        if (mode) y_next = (state_next < EXP_TH);
      end
`else
      always_comb begin
        y_next = (state_next >= MID_STATE);
      end
`endif

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= MID_STATE;
          y_reg     <= 1'b0;
        end else if (clr) begin
          state_reg <= MID_STATE;
          y_reg     <= 1'b0;
        end else if (bus.in_valid) begin
          state_reg <= state_next;
          y_reg     <= y_next;
        end
      end

      assign bus.Y[gi] = y_reg;
    end
  endgenerate

  // out_valid is a registered copy of in_valid, forced low by clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
    end else if (clr) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
    end
  end

  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_stoch_fsm_act.sv
// ----------------------------------------------------------------------------
// tb_stoch_fsm_act
//   Directed bench for stoch_fsm_act with CH=4, N_STATES=8, G=2.
//   Each step drives inputs just after a rising edge, waits for the next
//   rising edge and samples Y/out_valid 1 time unit later. Expected values
//   are hand-derived from the per-channel state sequence noted next to
//   each step (state threshold for tanh is 4, exp threshold is 6).
// ----------------------------------------------------------------------------
module tb_stoch_fsm_act;

  logic clk;
  logic rst;
  logic clr;
  logic mode;

  int checks;
  int errors;

  stoch_fsm_act_if #(.CH(4)) bus ();

  stoch_fsm_act #(
    .CH       (4),
    .N_STATES (8),
    .G        (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .mode (mode),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then check Y and out_valid.
  task automatic step(input logic [3:0] x, input logic v, input logic c, input logic m,
                      input logic [3:0] ey, input logic eov, input string tag);
    bus.X        = x;
    bus.in_valid = v;
    clr          = c;
    mode         = m;
    @(posedge clk);
    #1;
    chk({tag, ".y"}, bus.Y, ey);
    chk({tag, ".ov"}, {3'b000, bus.out_valid}, {3'b000, eov});
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    clr          = 1'b0;
    mode         = 1'b0;
    bus.in_valid = 1'b0;
    bus.X        = 4'h0;

    // Reset: states 4, Y=0, out_valid=0.
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.y", bus.Y, 4'h0);
    chk("rst.ov", {3'b000, bus.out_valid}, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel.y", bus.Y, 4'h0);
    chk("rst_rel.ov", {3'b000, bus.out_valid}, 4'h0);

    // Count up: states 5,6,7,7 -> Y=1111 each, out_valid from the first edge.
    for (int i = 0; i < 4; i++) step(4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, "up");
    // Down from the top: 6,5,4 -> Y=1, then 3 -> Y=0 (state pinned at 7).
    for (int i = 0; i < 3; i++) step(4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, "dn_hi");
    step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "dn_mid");

    // clr with in_valid: X lost, Y=0, out_valid=0, states back to 4.
    step(4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "clr1");
    // One X=0 -> 3; seven more -> 2,1,0,0,0,0,0; all Y=0.
    step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "dec1");
    for (int i = 0; i < 7; i++) step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "dec_sat");
    // Out of the floor: 1,2,3 -> Y=0, then 4 -> Y=1 (state pinned at 0).
    for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "inc_lo");
    step(4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, "inc_mid");

    // clr with in_valid=0; then independent channels.
    step(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "clr2");
    // X=0101: ch0 5, ch1 3, ch2 5, ch3 3 -> Y=0101.
    step(4'h5, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1, "ind1");
    // X=1001: ch0 6, ch1 2, ch2 4, ch3 4 -> Y=1101.
    step(4'h9, 1'b1, 1'b0, 1'b0, 4'hD, 1'b1, "ind2");

    // Stall 5 cycles: Y and state frozen, out_valid=0.
    for (int i = 0; i < 5; i++) step(4'h0, 1'b0, 1'b0, 1'b0, 4'hD, 1'b0, "stall");
    // Resume X=0000: ch0 5, ch1 1, ch2 3, ch3 3 -> Y=0001.
    step(4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, "resume");

    // clr beats in_valid, then X=1 -> 5 (confirmed by 4 -> Y=1, 3 -> Y=0).
    step(4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "clr3");
    step(4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, "post_clr5");
    step(4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, "post_clr4");
    step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "post_clr3");

    // Mode handling, from state 4.
    step(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "clr4");
`ifdef STOCH_ACT_EXP_EN
    // Exp (Y=1 when state<6): 5,6,7 -> 1,0,0; then 6,5 -> 0,1.
    step(4'hF, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, "exp5");
    step(4'hF, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "exp6");
    step(4'hF, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "exp7");
    step(4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "exp6b");
    step(4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, "exp5b");
    // Mode toggling; state walks 6,7,7,6,5,4,3 regardless of mode.
    step(4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, "tog_t6");
    step(4'hF, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "tog_e7");
    step(4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, "tog_t7");
    step(4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "tog_e6");
    step(4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, "tog_t5");
    step(4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, "tog_e4");
    step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "tog_t3");
`else
    // mode=1 is ignored: tanh throughout. 5,6,7 -> 1; 6,5,4 -> 1; 3 -> 0.
    for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, "noexp_up");
    for (int i = 0; i < 3; i++) step(4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, "noexp_dn");
    step(4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "noexp_3");
`endif

    // Async reset mid-stream from state 3: climb to 6, then pull rst.
    for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 1'b0, 1'b0, (i == 0) ? 4'hF : 4'hF, 1'b1, "pre_rst");
    #2 rst = 1'b0;
    #1;
    chk("arst.y", bus.Y, 4'h0);
    chk("arst.ov", {3'b000, bus.out_valid}, 4'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // First valid input after reset counts from 4: X=0 -> 3, X=1 -> 4.
    step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "arst_dn");
    step(4'hF, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, "arst_up");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
